// File: rtl/parallel_to_serial_pkg.sv
// Shared types and helpers for the parallel_to_serial transmitter.
// Parity option: define PARALLEL_TO_SERIAL_PARITY_EN to append an even-parity bit.
package parallel_to_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Bits shifted per word, including the optional parity bit.
  function automatic int nbits_f(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parallel_to_serial_bit_timer.sv
// Bit-period divider: counts DIVIDE system clocks per serial bit.
// Ports: clock, resetN, run in; bitEnd (last clock of bit), shiftClock out.
module bit_timer #(
  parameter int DIVIDE = 4
) (
  input  logic clock,
  input  logic resetN,
  input  logic run,
  output logic bitEnd,
  output logic shiftClock
);

  localparam int DW = $clog2(DIVIDE);
  localparam logic [DW-1:0] LAST = DW'(DIVIDE - 1);
  localparam logic [DW-1:0] HALF = DW'(DIVIDE / 2);

  logic [DW-1:0] divCount_q;
  logic [DW-1:0] divCount_d;

  assign bitEnd = (divCount_q == LAST);

  // High in the second half of the bit, so data is settled before the rise.
  assign shiftClock = run && (divCount_q >= HALF);

  // Held at zero while idle, so a new word always starts at phase 0.
  always_comb begin
    divCount_d = divCount_q;
    if (!run) begin
      divCount_d = '0;
    end else if (bitEnd) begin
      divCount_d = '0;
    end else begin
      divCount_d = divCount_q + DW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      divCount_q <= '0;
    end else begin
      divCount_q <= divCount_d;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel-in/serial-out transmitter, MSB first, with shiftClock and latchStrobe.
// Ports: clock, resetN, dataIn, dataValid in; dataReady, serialData, shiftClock,
// latchStrobe, busy out. Option macro: PARALLEL_TO_SERIAL_PARITY_EN.
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIVIDE = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             dataValid,
  output logic             dataReady,
  output logic             serialData,
  output logic             shiftClock,
  output logic             latchStrobe,
  output logic             busy
);

  localparam int NBITS = nbits_f(WIDTH);
  localparam int BW    = $clog2(NBITS);
  localparam logic [BW-1:0] LASTBIT = BW'(NBITS - 1);

  state_e state_q;
  state_e state_d;

  logic [NBITS-1:0] shreg_q;
  logic [NBITS-1:0] shreg_d;
  logic [BW-1:0]    bitCount_q;
  logic [BW-1:0]    bitCount_d;
  logic [NBITS-1:0] loadWord;
  logic             bitEnd;
  logic             run;

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  assign loadWord = {dataIn, even_parity(64'(dataIn))};
`else
  assign loadWord = dataIn;
`endif

  assign run = (state_q == SHIFT);

  bit_timer #(
    .DIVIDE(DIVIDE)
  ) u_timer (
    .clock     (clock),
    .resetN    (resetN),
    .run       (run),
    .bitEnd    (bitEnd),
    .shiftClock(shiftClock)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitCount_d = bitCount_q;
    unique case (state_q)
      IDLE: begin
        if (dataValid) begin
          shreg_d    = loadWord;
          bitCount_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (bitEnd) begin
          if (bitCount_q == LASTBIT) begin
            state_d = LATCH;
          end else begin
            shreg_d    = {shreg_q[NBITS-2:0], 1'b0};
            bitCount_d = bitCount_q + BW'(1);
          end
        end
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitCount_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitCount_q <= bitCount_d;
    end
  end

  assign dataReady   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign latchStrobe = (state_q == LATCH);
  assign serialData  = run & shreg_q[NBITS-1];

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial against a cycle-timeline model.
// Honours PARALLEL_TO_SERIAL_PARITY_EN for the expected bit count.
module tb_parallel_to_serial;

  localparam int WIDTH  = 8;
  localparam int DIVIDE = 4;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int WORDCYC = NB * DIVIDE;

  logic             clock = 1'b0;
  logic             resetN = 1'b0;
  logic             dataValid = 1'b0;
  logic [WIDTH-1:0] dataIn = '0;
  logic             dataReady;
  logic             serialData;
  logic             shiftClock;
  logic             latchStrobe;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  parallel_to_serial #(
    .WIDTH (WIDTH),
    .DIVIDE(DIVIDE)
  ) dut (
    .clock      (clock),
    .resetN     (resetN),
    .dataIn     (dataIn),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .serialData (serialData),
    .shiftClock (shiftClock),
    .latchStrobe(latchStrobe),
    .busy       (busy)
  );

  // Bit k of the transmitted stream: data MSB first, then parity.
  function automatic logic ref_bit(input logic [WIDTH-1:0] w, input int k);
    if (k < WIDTH) return w[WIDTH-1-k];
    return ^w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, dataReady, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_serial"}, serialData, 1'b0);
    chk({tag, "_sclk"}, shiftClock, 1'b0);
    chk({tag, "_strobe"}, latchStrobe, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk_idle("idle");
    end
  endtask

  // Caller is at a negedge with the DUT idle. Handshake on the next edge,
  // then every cycle of the word is compared with the timeline.
  task automatic run_word(input logic [WIDTH-1:0] w, input bit hold,
                          input logic [WIDTH-1:0] nxt, input int junk_cyc);
    logic [NB-1:0] rx;
    logic [NB-1:0] expw;
    int            nrx;
    logic          prev_sc;
    rx      = '0;
    expw    = '0;
    nrx     = 0;
    prev_sc = 1'b0;
    for (int k = 0; k < NB; k++) expw[NB-1-k] = ref_bit(w, k);
    dataIn    = w;
    dataValid = 1'b1;
    chk("ready_pre", dataReady, 1'b1);
    for (int c = 1; c <= WORDCYC + 2; c++) begin
      @(negedge clock);
      if (c <= WORDCYC) begin
        int k;
        int ph;
        k  = (c - 1) / DIVIDE;
        ph = (c - 1) % DIVIDE;
        chk("serial", serialData, ref_bit(w, k));
        chk("sclk", shiftClock, ph >= DIVIDE / 2);
        chk("strobe_lo", latchStrobe, 1'b0);
        chk("busy", busy, 1'b1);
        chk("ready_lo", dataReady, 1'b0);
      end else if (c == WORDCYC + 1) begin
        chk("strobe_hi", latchStrobe, 1'b1);
        chk("latch_serial", serialData, 1'b0);
        chk("latch_sclk", shiftClock, 1'b0);
        chk("latch_busy", busy, 1'b1);
        chk("rx_word", 32'(rx), 32'(expw));
        chk("rx_edges", nrx, NB);
      end else begin
        chk_idle("back");
      end
      if (shiftClock && !prev_sc) begin
        rx = {rx[NB-2:0], serialData};
        nrx++;
      end
      prev_sc = shiftClock;
      if (hold) begin
        dataValid = 1'b1;
        dataIn    = nxt;
      end else if (c == junk_cyc) begin
        dataValid = 1'b1;
        dataIn    = 8'hFF;
      end else begin
        dataValid = 1'b0;
        dataIn    = WIDTH'($urandom);
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    bit               hold;
    int               junk;

    // Reset with a valid word presented: must be ignored.
    resetN    = 1'b0;
    dataValid = 1'b1;
    dataIn    = 8'h96;
    repeat (3) @(negedge clock);
    chk_idle("reset");
    resetN    = 1'b1;
    dataValid = 1'b0;
    @(negedge clock);
    chk_idle("post_reset");

    run_word(8'hA5, 1'b0, '0, -1);
    idle(2);

    // Back-to-back with valid held high.
    run_word(8'h3C, 1'b1, 8'hC3, -1);
    run_word(8'hC3, 1'b0, '0, -1);
    idle(1);

    // Valid pulse with 8'hFF while busy must be ignored.
    run_word(8'h5A, 1'b0, '0, 10);
    idle(1);

    run_word(8'h07, 1'b0, '0, -1);
    run_word(8'h03, 1'b0, '0, -1);
    idle(1);

    cur = WIDTH'($urandom);
    for (int i = 0; i < 10; i++) begin
      hold = (i == 9) ? 1'b0 : 1'($urandom_range(0, 1));
      nxt  = WIDTH'($urandom);
      junk = ($urandom_range(0, 2) == 0) ?
             int'($urandom_range(1, WORDCYC - 1)) : -1;
      run_word(cur, hold, nxt, junk);
      if (hold) begin
        cur = nxt;
      end else begin
        idle(int'($urandom_range(0, 3)));
        cur = WIDTH'($urandom);
      end
    end
    idle(1);

    // Reset during bit 3 of 8'h81.
    dataIn    = 8'h81;
    dataValid = 1'b1;
    @(negedge clock);
    dataValid = 1'b0;
    repeat (13) @(negedge clock);
    chk("mid_busy", busy, 1'b1);
    chk("mid_serial", serialData, ref_bit(8'h81, 3));
    resetN = 1'b0;
    @(negedge clock);
    chk("abort_sclk", shiftClock, 1'b0);
    chk("abort_serial", serialData, 1'b0);
    chk("abort_strobe", latchStrobe, 1'b0);
    dataValid = 1'b1;
    dataIn    = WIDTH'($urandom);
    repeat (2) begin
      @(negedge clock);
      chk("rst_busy", busy, 1'b0);
    end
    resetN    = 1'b1;
    dataValid = 1'b0;
    @(negedge clock);
    chk_idle("release");
    idle(WORDCYC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
